cdc_capture_deser: RTL and testbench

- Downstream consumer of a single-bit data line launched from a foreign clock domain, e.g. the output of a two-flop cross-domain capture stage.
- Resynchronizes the bit into the local clock and shifts it, MSB first, into WIDTH-bit words.
- Presents each word on a valid/ready output with a one-entry holding buffer and a sticky overflow flag.
- Gives the STA flow a real synchronizer, handshake and counter paths on the capturing side.

---
 rtl/cdc_capture_deser.sv | 114 +++++++++++
 tb/tb_cdc_capture_deser.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cdc_capture_deser.sv
// Resynchronizes a foreign-domain serial bit and deserializes it MSB-first into words on a valid/ready output.
// Optional edge counter on the synchronized bit is built when CDC_CAPTURE_DESER_EDGE_CNT_EN is defined.
module cdc_capture_deser #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int unsigned BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   din_s;
  logic [WIDTH-2:0]       sreg;
  logic [BCW-1:0]         bit_cnt;
  logic [WIDTH-1:0]       word_c;
  logic                   complete_c;
  state_t                 state_q;
  state_t                 state_d;
  logic                   load_c;
  logic                   drop_c;

  assign din_s      = sync[SYNC_STAGES-1];
  assign word_c     = {sreg, din_s};
  assign complete_c = en && (bit_cnt == BCW'(WIDTH - 1));
  assign out_valid  = (state_q == FULL);

  // Synchronizer chain runs every cycle; only its first stage touches din.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], din};
  end

  // Shift register and bit counter; the counter wraps on completion so words abut.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      sreg    <= word_c[WIDTH-2:0];
      bit_cnt <= complete_c ? '0 : bit_cnt + BCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Holding buffer: a completion while FULL either replaces a consumed word or is dropped.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    drop_c  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete_c) begin
          load_c  = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete_c && out_ready)  load_c  = 1'b1;
        else if (complete_c)          drop_c  = 1'b1;
        else if (out_ready)           state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (load_c) out_data <= word_c;
      if (drop_c)       overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef CDC_CAPTURE_DESER_EDGE_CNT_EN
  logic             din_s_q;
  logic [CNT_W-1:0] cnt_q;

  // Saturating transition count on the synchronized bit, independent of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_s_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      din_s_q <= din_s;
      if ((din_s != din_s_q) && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign edge_cnt = cnt_q;
`else
  assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_cdc_capture_deser.sv
// Directed self-checking bench for cdc_capture_deser; a second CNT_W=4 instance covers edge-count saturation.
module tb_cdc_capture_deser;

  logic       clk = 1'b0;
  logic       rst, din, en, out_ready, clr_ovf;
  logic [7:0] out_data;
  logic       out_valid, overflow;
  logic [7:0] edge_cnt;

  logic       rst4, din4;
  logic [7:0] out_data4;
  logic       out_valid4, overflow4;
  logic [3:0] edge_cnt4;

  int n_checks = 0;
  int n_err    = 0;

`ifdef CDC_CAPTURE_DESER_EDGE_CNT_EN
  localparam int unsigned EXP_E10 = 10;
  localparam int unsigned EXP_E20 = 15;
`else
  localparam int unsigned EXP_E10 = 0;
  localparam int unsigned EXP_E20 = 0;
`endif

  always #5 clk = ~clk;

  cdc_capture_deser #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_data(out_data), .out_valid(out_valid), .overflow(overflow), .edge_cnt(edge_cnt)
  );

  cdc_capture_deser #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .din(din4), .en(en), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_data(out_data4), .out_valid(out_valid4), .overflow(overflow4), .edge_cnt(edge_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n bits MSB-first on din; en trails by the 2-cycle sync latency so din_s lines up.
  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) din = bits[n-1-i];
      en = (i >= 2);
      step();
    end
    en = 1'b0;
  endtask

  initial begin
    logic [15:0] pair;
    rst = 1'b1; din = 1'b1; en = 1'b1; out_ready = 1'b0; clr_ovf = 1'b0;
    rst4 = 1'b1; din4 = 1'b0;
    repeat (3) step();
    check("rst_data",  32'(out_data),  32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ovf",   32'(overflow),  32'h0);
    check("rst_edge",  32'(edge_cnt),  32'h0);
    check("rst4_data", 32'(out_data4), 32'h0);
    check("rst4_valid", 32'(out_valid4), 32'h0);
    check("rst4_ovf",  32'(overflow4), 32'h0);
    check("rst4_edge", 32'(edge_cnt4), 32'h0);

    rst = 1'b0; en = 1'b0;
    step();
    check("din_s_lat1", 32'(dut.din_s), 32'h0);
    step();
    check("din_s_lat2", 32'(dut.din_s), 32'h1);

    // Single word with consumer always ready.
    out_ready = 1'b1;
    shift_bits(32'hA5, 8);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data",  32'(out_data),  32'hA5);
    step();
    check("single_valid_drop", 32'(out_valid), 32'h0);
    check("single_ovf", 32'(overflow), 32'h0);

    // Overflow: second word dropped while the first is held.
    out_ready = 1'b0;
    shift_bits(32'h3C, 8);
    check("ovf_first", 32'(out_data), 32'h3C);
    shift_bits(32'hFF, 8);
    check("ovf_hold",  32'(out_data),  32'h3C);
    check("ovf_valid", 32'(out_valid), 32'h1);
    check("ovf_set",   32'(overflow),  32'h1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("ovf_consumed", 32'(out_valid), 32'h0);

    // Back-to-back words; consume word 1 on word 2's completing cycle.
    pair = 16'h5AC3;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) din = pair[15-i];
      en = (i >= 2);
      out_ready = (i == 17);
      step();
      if (i == 9) begin
        check("b2b_w1_valid", 32'(out_valid), 32'h1);
        check("b2b_w1_data",  32'(out_data),  32'h5A);
      end
    end
    en = 1'b0; out_ready = 1'b0;
    check("b2b_w2_data",  32'(out_data),  32'hC3);
    check("b2b_w2_valid", 32'(out_valid), 32'h1);
    check("b2b_ovf",      32'(overflow),  32'h0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Reset mid-word, then a clean word.
    shift_bits(32'h1F, 5);
    din = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    shift_bits(32'h40, 7);
    check("midrst_not_yet", 32'(out_valid), 32'h0);
    shift_bits(32'h1, 1);
    check("midrst_valid", 32'(out_valid), 32'h1);
    check("midrst_data",  32'(out_data),  32'h81);

    // Edge counter: 10 toggles on the main instance.
    din = 1'b0; rst = 1'b1; step(); step(); rst = 1'b0;
    check("edge_clear", 32'(edge_cnt), 32'h0);
    for (int i = 0; i < 10; i++) begin
      din = ~din;
      repeat (3) step();
    end
    repeat (2) step();
    check("edge_10", 32'(edge_cnt), EXP_E10);

    // Saturation on the CNT_W=4 instance.
    rst4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din4 = ~din4;
      repeat (3) step();
    end
    repeat (2) step();
    check("edge_sat", 32'(edge_cnt4), EXP_E20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
